// File: rtl/sum_launcher_if.sv
// Operand-stream and result-stream handshake bundle for sum_launcher.
// The slave modport is the launcher side; master is the producer/consumer side.
interface sum_launcher_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_last;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [2:0]  res_status;

   modport master (
      output in_valid, in_a, in_b, in_last, res_ready,
      input  in_ready, res_valid, res_data, res_status
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, res_ready,
      output in_ready, res_valid, res_data, res_status
   );
endinterface

// File: rtl/sum_launcher.sv
// Host-side launcher for the array-sum kernel: fills operand memories a/b,
// pulses start, serves kernel memory accesses, then returns the kernel result.
module sum_launcher #(
   parameter int DEPTH   = 64,
   parameter int ADDR_W  = 6,
   parameter int TIMEOUT = 4096
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   sum_launcher_if.slave bus,
   output logic        k_start,
   output logic [31:0] k_n,
   input  logic        k_done,
   input  logic [31:0] k_return_val,
   input  logic [31:0] a_address0,
   input  logic        a_ce0,
   input  logic        a_we0,
   input  logic [31:0] a_ad0,
   output logic [31:0] a_q0,
   input  logic [31:0] b_address0,
   input  logic        b_ce0,
   input  logic        b_we0,
   input  logic [31:0] b_ad0,
   output logic [31:0] b_q0,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {LOAD, LAUNCH, RUN, RESULT} state_t;

   state_t            state, next_state;
   logic [31:0]       a_mem [DEPTH];
   logic [31:0]       b_mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   count;
   logic [TW-1:0]     timer;
   logic              trunc_flag, addr_err_flag, timeout_flag;
   logic [31:0]       res_data_q;

   logic accept, mem_full, load_done, timer_expired, in_run;
   logic a_oob, b_oob, a_rd, a_wr, b_rd, b_wr;

   assign accept        = bus.in_valid && bus.in_ready;
   assign mem_full      = (wr_ptr == ADDR_W'(DEPTH - 1));
   assign load_done     = accept && (bus.in_last || mem_full);
   assign timer_expired = (timer == TW'(TIMEOUT - 1));
   assign in_run        = (state == RUN);

   // Any address bit above the memory index range marks an out-of-bounds access
   assign a_oob = |a_address0[31:ADDR_W];
   assign b_oob = |b_address0[31:ADDR_W];
   assign a_rd  = in_run && a_ce0 && !a_we0;
   assign a_wr  = in_run && a_ce0 && a_we0;
   assign b_rd  = in_run && b_ce0 && !b_we0;
   assign b_wr  = in_run && b_ce0 && b_we0;

   assign k_n            = 32'(count);
   assign bus.res_data   = res_data_q;
   assign bus.res_status = {trunc_flag, addr_err_flag, timeout_flag};

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= LOAD;
      else         state <= next_state;
   end

   always_comb begin
      next_state    = state;
      bus.in_ready  = 1'b0;
      bus.res_valid = 1'b0;
      k_start       = 1'b0;
      busy          = 1'b0;
      case (state)
         LOAD: begin
            bus.in_ready = !sys_rst;
            if (load_done) next_state = LAUNCH;
         end
         LAUNCH: begin
            k_start    = 1'b1;
            busy       = 1'b1;
            next_state = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (k_done || timer_expired) next_state = RESULT;
         end
         RESULT: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready) next_state = LOAD;
         end
         default: next_state = LOAD;
      endcase
   end

   // Memories are never cleared by reset; contents survive across jobs
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         if (accept)            a_mem[wr_ptr] <= bus.in_a;
         else if (a_wr && !a_oob) a_mem[a_address0[ADDR_W-1:0]] <= a_ad0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         if (accept)            b_mem[wr_ptr] <= bus.in_b;
         else if (b_wr && !b_oob) b_mem[b_address0[ADDR_W-1:0]] <= b_ad0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         a_q0 <= '0;
         b_q0 <= '0;
      end else begin
         if (a_rd) a_q0 <= a_oob ? 32'd0 : a_mem[a_address0[ADDR_W-1:0]];
         if (b_rd) b_q0 <= b_oob ? 32'd0 : b_mem[b_address0[ADDR_W-1:0]];
      end
   end

   // Job bookkeeping: fill pointer, element count, timeout timer, result and flags
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr        <= '0;
         count         <= '0;
         timer         <= '0;
         trunc_flag    <= 1'b0;
         addr_err_flag <= 1'b0;
         timeout_flag  <= 1'b0;
         res_data_q    <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
               if (load_done) begin
                  count      <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
                  trunc_flag <= !bus.in_last;
               end
            end
            LAUNCH: timer <= '0;
            RUN: begin
               timer <= timer + TW'(1);
               if ((a_ce0 && a_oob) || (b_ce0 && b_oob)) addr_err_flag <= 1'b1;
               if (k_done) begin
                  res_data_q <= k_return_val;
               end else if (timer_expired) begin
                  res_data_q   <= '0;
                  timeout_flag <= 1'b1;
               end
            end
            RESULT: begin
               if (bus.res_ready) begin
                  wr_ptr        <= '0;
                  count         <= '0;
                  trunc_flag    <= 1'b0;
                  addr_err_flag <= 1'b0;
                  timeout_flag  <= 1'b0;
                  res_data_q    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_launcher.sv
// Directed bench for sum_launcher: stimulus pushes expected results into a
// scoreboard queue that a separate monitor drains on each result handshake.
module tb_sum_launcher;
   localparam int DEPTH   = 64;
   localparam int ADDR_W  = 6;
   localparam int TIMEOUT = 4096;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        k_start, k_done, busy;
   logic [31:0] k_n, k_return_val;
   logic [31:0] a_address0, a_ad0, a_q0, b_address0, b_ad0, b_q0;
   logic        a_ce0, a_we0, b_ce0, b_we0;

   int pass_count  = 0;
   int check_count = 0;
   logic [34:0] exp_q [$];

   sum_launcher_if bus ();

   sum_launcher #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus),
      .k_start(k_start), .k_n(k_n), .k_done(k_done), .k_return_val(k_return_val),
      .a_address0(a_address0), .a_ce0(a_ce0), .a_we0(a_we0), .a_ad0(a_ad0), .a_q0(a_q0),
      .b_address0(b_address0), .b_ce0(b_ce0), .b_we0(b_we0), .b_ad0(b_ad0), .b_q0(b_q0),
      .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // One operand beat; in_ready must be high while the beat is offered
   task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic last);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_last  = last;
      check_output("in_ready_load", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_result(input int budget, output int cycles);
      cycles = 0;
      while (!bus.res_valid && cycles < budget) begin
         tick();
         cycles++;
      end
      if (!bus.res_valid) begin
         check_output("res_valid_wait", 64'd0, 64'd1);
      end else begin
         bus.res_ready = 1'b1;
         tick();
         bus.res_ready = 1'b0;
      end
   endtask

   task automatic kernel_access(input logic [31:0] aa, input logic ace, input logic awe, input logic [31:0] ad,
                                input logic [31:0] ba, input logic bce, input logic bwe, input logic [31:0] bd);
      a_address0 = aa; a_ce0 = ace; a_we0 = awe; a_ad0 = ad;
      b_address0 = ba; b_ce0 = bce; b_we0 = bwe; b_ad0 = bd;
      tick();
      a_ce0 = 1'b0; a_we0 = 1'b0; b_ce0 = 1'b0; b_we0 = 1'b0;
   endtask

   task automatic finish_job(input logic [31:0] val, input logic [2:0] status);
      int cyc;
      exp_q.push_back({val, status});
      k_done       = 1'b1;
      k_return_val = val;
      tick();
      k_done = 1'b0;
      check_output("res_valid_after_done", 64'(bus.res_valid), 64'd1);
      wait_result(2, cyc);
   endtask

   // Monitor: every accepted result is matched against the oldest expectation
   always @(negedge sys_clk) begin
      if (!sys_rst && bus.res_valid && bus.res_ready) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_result", 64'({bus.res_data, bus.res_status}), 64'd0);
         end else begin
            logic [34:0] e;
            e = exp_q.pop_front();
            check_output("result", 64'({bus.res_data, bus.res_status}), 64'(e));
         end
      end
   end

   initial begin
      int cyc;
      sys_rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
      k_done = 1'b0; k_return_val = '0;
      a_address0 = '0; a_ce0 = 1'b0; a_we0 = 1'b0; a_ad0 = '0;
      b_address0 = '0; b_ce0 = 1'b0; b_we0 = 1'b0; b_ad0 = '0;
      tick();
      tick();
      check_output("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check_output("rst_res_valid", 64'(bus.res_valid), 64'd0);
      check_output("rst_res_data", 64'(bus.res_data), 64'd0);
      check_output("rst_res_status", 64'(bus.res_status), 64'd0);
      check_output("rst_k_start", 64'(k_start), 64'd0);
      check_output("rst_k_n", 64'(k_n), 64'd0);
      check_output("rst_q0", 64'({a_q0, b_q0}), 64'd0);
      check_output("rst_busy", 64'(busy), 64'd0);
      sys_rst = 1'b0;
      tick();
      check_output("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

      // Four-pair job, read back addr 2, kernel returns 110, stalled result
      for (int i = 1; i <= 4; i++) apply_stimulus(32'(i), 32'(i * 10), i == 4);
      check_output("k_start_pulse", 64'(k_start), 64'd1);
      check_output("k_n_four", 64'(k_n), 64'd4);
      check_output("in_ready_drop", 64'(bus.in_ready), 64'd0);
      check_output("busy_launch", 64'(busy), 64'd1);
      tick();
      check_output("k_start_single", 64'(k_start), 64'd0);
      kernel_access(32'd2, 1'b1, 1'b0, 32'd0, 32'd2, 1'b1, 1'b0, 32'd0);
      check_output("read_a2", 64'(a_q0), 64'd3);
      check_output("read_b2", 64'(b_q0), 64'd30);
      exp_q.push_back({32'd110, 3'b000});
      k_done = 1'b1; k_return_val = 32'd110;
      tick();
      k_done = 1'b0;
      check_output("res_valid_d1", 64'(bus.res_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         check_output("stall_data", 64'({bus.res_valid, bus.res_data, bus.res_status}), 64'({1'b1, 32'd110, 3'b000}));
         check_output("stall_k_n", 64'(k_n), 64'd4);
         tick();
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      check_output("in_ready_after_accept", 64'(bus.in_ready), 64'd1);

      // Full memory without in_last: truncated launch with k_n=DEPTH
      for (int i = 0; i < DEPTH; i++) apply_stimulus(32'(i + 100), 32'(i + 200), 1'b0);
      check_output("trunc_k_start", 64'(k_start), 64'd1);
      check_output("trunc_k_n", 64'(k_n), 64'd64);
      tick();
      kernel_access(32'd63, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
      check_output("read_a63", 64'(a_q0), 64'd163);
      check_output("read_b0", 64'(b_q0), 64'd200);
      finish_job(32'd555, 3'b100);

      // Kernel never finishes: timeout after TIMEOUT cycles in RUN
      apply_stimulus(32'd7, 32'd8, 1'b1);
      check_output("to_k_start", 64'(k_start), 64'd1);
      exp_q.push_back({32'd0, 3'b001});
      wait_result(TIMEOUT + 100, cyc);
      check_output("timeout_latency", 64'(cyc), 64'(TIMEOUT + 1));

      // Done on the expiry cycle: done wins
      apply_stimulus(32'd9, 32'd10, 1'b1);
      repeat (TIMEOUT) tick();
      check_output("no_early_timeout", 64'(bus.res_valid), 64'd0);
      finish_job(32'd999, 3'b000);

      // Out-of-range kernel accesses set the address error flag
      apply_stimulus(32'd5, 32'd50, 1'b0);
      apply_stimulus(32'd6, 32'd60, 1'b1);
      tick();
      kernel_access(32'd64, 1'b1, 1'b0, 32'd0, 32'd1, 1'b1, 1'b0, 32'd0);
      check_output("oob_read_zero", 64'(a_q0), 64'd0);
      check_output("inrange_read_b1", 64'(b_q0), 64'd60);
      kernel_access(32'd100, 1'b1, 1'b1, 32'hDEAD, 32'd3, 1'b1, 1'b1, 32'd77);
      kernel_access(32'd36, 1'b1, 1'b0, 32'd0, 32'd3, 1'b1, 1'b0, 32'd0);
      check_output("dropped_write", 64'(a_q0), 64'd136);
      check_output("kernel_write_b3", 64'(b_q0), 64'd77);
      check_output("addr_err_status", 64'(bus.res_status), 64'b010);
      finish_job(32'd42, 3'b010);
      apply_stimulus(32'd1, 32'd2, 1'b1);
      tick();
      finish_job(32'd1, 3'b000);

      // Reset in RUN: back to LOAD, pending job discarded, memory kept
      apply_stimulus(32'd11, 32'd22, 1'b1);
      tick();
      tick();
      sys_rst = 1'b1;
      tick();
      check_output("rst_run_k_start", 64'(k_start), 64'd0);
      check_output("rst_run_res_valid", 64'(bus.res_valid), 64'd0);
      check_output("rst_run_busy", 64'(busy), 64'd0);
      sys_rst = 1'b0;
      tick();
      check_output("rst_run_in_ready", 64'(bus.in_ready), 64'd1);
      apply_stimulus(32'd12, 32'd13, 1'b1);
      check_output("post_rst_k_n", 64'(k_n), 64'd1);
      tick();
      kernel_access(32'd0, 1'b1, 1'b0, 32'd0, 32'd1, 1'b1, 1'b0, 32'd0);
      check_output("post_rst_a0", 64'(a_q0), 64'd12);
      check_output("post_rst_b1_kept", 64'(b_q0), 64'd60);
      finish_job(32'd321, 3'b000);

      repeat (3) tick();
      check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
